sw_field_ctrl: RTL and testbench

SW_FIELD_CTRL -- requirements
Module: sw_field_ctrl

---
 rtl/sw_field_ctrl_if.sv | 29 ++
 rtl/sw_field_ctrl.sv | 158 +++++++++++++++
 tb/tb_sw_field_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_field_ctrl_if.sv
// Access bundle for sw_field_ctrl: software/hardware strobes in, field state and status pulses out.
interface sw_field_ctrl_if #(
    parameter int F_WIDTH = 4,
    parameter int SW_CNT  = 1
);
    logic [SW_CNT-1:0]         sw_wr;
    logic [SW_CNT-1:0]         sw_rd;
    logic [F_WIDTH*SW_CNT-1:0] sw_wr_data;
    logic [F_WIDTH*SW_CNT-1:0] sw_wr_mask;
    logic                      hw_we;
    logic [F_WIDTH-1:0]        hw_wr_data;
    logic [F_WIDTH-1:0]        field_value;
    logic [F_WIDTH-1:0]        rd_data;
    logic                      swmod_out;
    logic                      swacc_out;
    logic                      written_once;
    logic                      pulse_busy;
    logic                      parity_err;

    modport master (
        output sw_wr, sw_rd, sw_wr_data, sw_wr_mask, hw_we, hw_wr_data,
        input  field_value, rd_data, swmod_out, swacc_out, written_once, pulse_busy, parity_err
    );

    modport slave (
        input  sw_wr, sw_rd, sw_wr_data, sw_wr_mask, hw_we, hw_wr_data,
        output field_value, rd_data, swmod_out, swacc_out, written_once, pulse_busy, parity_err
    );
endinterface

// File: rtl/sw_field_ctrl.sv
// Software-accessible register field: on-read/on-write side effects, write-once lock, pulse auto-clear.
// Define SW_FIELD_CTRL_PARITY_EN to add a sticky parity check on the field flops.
`ifndef SW_FIELD_CTRL_DEFS
`define SW_FIELD_CTRL_DEFS
`define SW_RO  0
`define SW_RW  1
`define SW_WO  2
`define SW_RW1 3
`define SW_W1  4
`define NA     0
`define RCLR   1
`define RSET   2
`define WOCLR  1
`define WOSET  2
`define WOT    3
`define WZS    4
`define WZC    5
`define WZT    6
`endif

module sw_field_ctrl #(
    parameter int                 F_WIDTH         = 4,
    parameter int                 SW_CNT          = 1,
    parameter int                 SW_TYPE         = `SW_RW,
    parameter int                 SW_ONREAD_TYPE  = `NA,
    parameter int                 SW_ONWRITE_TYPE = `NA,
    parameter int                 PULSE_LEN       = 0,
    parameter logic [F_WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic           clk,
    input  logic           rst,
    sw_field_ctrl_if.slave bus
);
    if (F_WIDTH < 1 || F_WIDTH > 64) begin : g_bad_f_width
        $fatal(1, "sw_field_ctrl: illegal F_WIDTH (legal 1..64)");
    end
    if (SW_CNT < 1 || SW_CNT > 8) begin : g_bad_sw_cnt
        $fatal(1, "sw_field_ctrl: illegal SW_CNT (legal 1..8)");
    end
    if (SW_TYPE < `SW_RO || SW_TYPE > `SW_W1) begin : g_bad_sw_type
        $fatal(1, "sw_field_ctrl: illegal SW_TYPE");
    end
    if (SW_ONREAD_TYPE < `NA || SW_ONREAD_TYPE > `RSET) begin : g_bad_onread
        $fatal(1, "sw_field_ctrl: illegal SW_ONREAD_TYPE");
    end
    if (SW_ONWRITE_TYPE < `NA || SW_ONWRITE_TYPE > `WZT) begin : g_bad_onwrite
        $fatal(1, "sw_field_ctrl: illegal SW_ONWRITE_TYPE");
    end
    if (PULSE_LEN < 0 || PULSE_LEN > 255) begin : g_bad_pulse_len
        $fatal(1, "sw_field_ctrl: illegal PULSE_LEN (legal 0..255)");
    end

    localparam bit WRITABLE = (SW_TYPE != `SW_RO);
    localparam bit READABLE = (SW_TYPE == `SW_RO) || (SW_TYPE == `SW_RW) || (SW_TYPE == `SW_RW1);
    localparam bit LOCKABLE = (SW_TYPE == `SW_RW1) || (SW_TYPE == `SW_W1);
    localparam bit PULSE_EN = (PULSE_LEN != 0);

    logic [F_WIDTH-1:0] field_q, field_next;
    logic [F_WIDTH-1:0] sel_data, sel_mask, wr_val;
    logic [7:0]         cnt_q, cnt_next;
    logic               wo_q, mod_q, acc_q;
    logic               wr_accept, rd_effect, auto_clear;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        sel_data = '0;
        sel_mask = '0;
        // Walk downwards so the lowest-indexed active port is the one left standing.
        for (int k = SW_CNT - 1; k >= 0; k--) begin
            if (bus.sw_wr[k]) begin
                sel_data = bus.sw_wr_data[k*F_WIDTH +: F_WIDTH];
                sel_mask = bus.sw_wr_mask[k*F_WIDTH +: F_WIDTH];
            end
        end
    end

    always_comb begin
        wr_val = sel_data;
        case (SW_ONWRITE_TYPE)
            `WOCLR:  wr_val = field_q & ~sel_data;
            `WOSET:  wr_val = field_q | sel_data;
            `WOT:    wr_val = field_q ^ sel_data;
            `WZS:    wr_val = field_q | ~sel_data;
            `WZC:    wr_val = field_q & sel_data;
            `WZT:    wr_val = field_q ^ ~sel_data;
            default: wr_val = sel_data;
        endcase
    end

    // A write that loses to the lock or the field type lets a same-cycle read side effect through.
    assign wr_accept  = WRITABLE && (|bus.sw_wr) && !(LOCKABLE && wo_q);
    assign rd_effect  = READABLE && (SW_ONREAD_TYPE != `NA) && (|bus.sw_rd) && !wr_accept;
    assign auto_clear = (cnt_q == 8'd1);

    always_comb begin
        field_next = field_q;
        if (wr_accept) begin
            field_next = (wr_val & sel_mask) | (field_q & ~sel_mask);
        end else if (rd_effect) begin
            field_next = (SW_ONREAD_TYPE == `RCLR) ? '0 : '1;
        end else if (bus.hw_we) begin
            field_next = bus.hw_wr_data;
        end else if (auto_clear) begin
            field_next = '0;
        end
    end

    always_comb begin
        cnt_next = 8'd0;
        if (PULSE_EN && wr_accept) begin
            cnt_next = 8'(PULSE_LEN);
        end else if (cnt_q != 8'd0) begin
            cnt_next = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
        if (rst) begin
            field_q <= RESET_VAL;
            wo_q    <= 1'b0;
            cnt_q   <= 8'd0;
            mod_q   <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            field_q <= field_next;
            wo_q    <= LOCKABLE && (wo_q || wr_accept);
            cnt_q   <= cnt_next;
            mod_q   <= wr_accept || rd_effect;
            acc_q   <= (|bus.sw_rd) || (|bus.sw_wr);
        end
    end

`ifdef SW_FIELD_CTRL_PARITY_EN
    logic par_q, perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= ^RESET_VAL;
            perr_q <= 1'b0;
        end else begin
            par_q  <= ^field_next;
            perr_q <= perr_q || (par_q != ^field_q);
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.field_value  = field_q;
    assign bus.rd_data      = READABLE ? field_q : '0;
    assign bus.swmod_out    = mod_q;
    assign bus.swacc_out    = acc_q;
    assign bus.written_once = wo_q;
    assign bus.pulse_busy   = (cnt_q != 8'd0);
endmodule

// File: tb/tb_sw_field_ctrl.sv
// Scoreboard bench: nine differently configured fields share one random stimulus stream and a reference model.
`ifndef SW_FIELD_CTRL_DEFS
`define SW_FIELD_CTRL_DEFS
`define SW_RO  0
`define SW_RW  1
`define SW_WO  2
`define SW_RW1 3
`define SW_W1  4
`define NA     0
`define RCLR   1
`define RSET   2
`define WOCLR  1
`define WOSET  2
`define WOT    3
`define WZS    4
`define WZC    5
`define WZT    6
`endif

module tb_sw_field_ctrl;
    localparam int N = 9;
    localparam int C_TYPE  [N] = '{`SW_RW, `SW_RW, `SW_RW, `SW_RW1, `SW_RW1, `SW_RW, `SW_RO, `SW_WO, `SW_W1};
    localparam int C_RD    [N] = '{`NA, `NA, `RCLR, `RSET, `NA, `NA, `RSET, `NA, `RCLR};
    localparam int C_WR    [N] = '{`NA, `WOCLR, `NA, `NA, `NA, `NA, `NA, `WZC, `WZT};
    localparam int C_PULSE [N] = '{0, 0, 0, 0, 3, 3, 0, 2, 0};
    localparam logic [7:0] C_RST [N] = '{8'h00, 8'hFF, 8'h5A, 8'h00, 8'h80, 8'h00, 8'h3C, 8'h0F, 8'h00};

    typedef struct packed {
        logic [N-1:0][7:0] rd;
        logic [N-1:0][7:0] fv;
        logic [N-1:0]      mod;
        logic [N-1:0]      acc;
        logic [N-1:0]      wo;
        logic [N-1:0]      busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sw_wr = '0;
    logic [1:0]  sw_rd = '0;
    logic [15:0] sw_wr_data = '0;
    logic [15:0] sw_wr_mask = '0;
    logic        hw_we = 1'b0;
    logic [7:0]  hw_wr_data = '0;

    logic [7:0] fv_o [N];
    logic [7:0] rd_o [N];
    logic       mod_o [N], acc_o [N], wo_o [N], busy_o [N], perr_o [N];

    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] mf [N];
    bit         mwo [N];
    int         mdl [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sw_field_ctrl_if #(.F_WIDTH(8), .SW_CNT(2)) bus ();

        assign bus.sw_wr      = sw_wr;
        assign bus.sw_rd      = sw_rd;
        assign bus.sw_wr_data = sw_wr_data;
        assign bus.sw_wr_mask = sw_wr_mask;
        assign bus.hw_we      = hw_we;
        assign bus.hw_wr_data = hw_wr_data;
        assign fv_o[g]   = bus.field_value;
        assign rd_o[g]   = bus.rd_data;
        assign mod_o[g]  = bus.swmod_out;
        assign acc_o[g]  = bus.swacc_out;
        assign wo_o[g]   = bus.written_once;
        assign busy_o[g] = bus.pulse_busy;
        assign perr_o[g] = bus.parity_err;

        sw_field_ctrl #(
            .F_WIDTH(8), .SW_CNT(2), .SW_TYPE(C_TYPE[g]), .SW_ONREAD_TYPE(C_RD[g]),
            .SW_ONWRITE_TYPE(C_WR[g]), .PULSE_LEN(C_PULSE[g]), .RESET_VAL(C_RST[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Applies one cycle of stimulus and pushes what every field should show for it.
    task automatic step(input bit r, input logic [1:0] w, input logic [1:0] rdv, input logic [15:0] d,
                        input logic [15:0] m, input bit he, input logic [7:0] hd);
        exp_t e;
        @(negedge clk);
        rst = r; sw_wr = w; sw_rd = rdv; sw_wr_data = d; sw_wr_mask = m; hw_we = he; hw_wr_data = hd;
        e = '0;
        for (int i = 0; i < N; i++) begin
            logic [7:0] f, dd, mm, wv;
            bit rdbl, lockable, accepted;
            f        = mf[i];
            rdbl     = (C_TYPE[i] == `SW_RO) || (C_TYPE[i] == `SW_RW) || (C_TYPE[i] == `SW_RW1);
            lockable = (C_TYPE[i] == `SW_RW1) || (C_TYPE[i] == `SW_W1);
            e.rd[i]  = rdbl ? f : 8'h00;
            if (r) begin
                mf[i] = C_RST[i]; mwo[i] = 1'b0; mdl[i] = -1;
            end else begin
                e.acc[i] = (w != 2'b00) || (rdv != 2'b00);
                dd = w[0] ? d[7:0] : d[15:8];
                mm = w[0] ? m[7:0] : m[15:8];
                accepted = (w != 2'b00) && (C_TYPE[i] != `SW_RO) && !(lockable && mwo[i]);
                case (C_WR[i])
                    `WOCLR:  wv = f & ~dd;
                    `WOSET:  wv = f | dd;
                    `WOT:    wv = f ^ dd;
                    `WZS:    wv = f | ~dd;
                    `WZC:    wv = f & dd;
                    `WZT:    wv = f ^ ~dd;
                    default: wv = dd;
                endcase
                if (accepted) begin
                    mf[i] = (wv & mm) | (f & ~mm);
                    if (lockable) mwo[i] = 1'b1;
                    if (C_PULSE[i] > 0) mdl[i] = cyc + C_PULSE[i];
                    e.mod[i] = 1'b1;
                end else if (rdbl && C_RD[i] != `NA && rdv != 2'b00) begin
                    mf[i] = (C_RD[i] == `RCLR) ? 8'h00 : 8'hFF;
                    e.mod[i] = 1'b1;
                end else if (he) begin
                    mf[i] = hd;
                end else if (mdl[i] == cyc) begin
                    mf[i] = 8'h00;
                end
            end
            e.fv[i]   = mf[i];
            e.wo[i]   = mwo[i];
            e.busy[i] = (mdl[i] > cyc);
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 8'h00);
    endtask

    task automatic wr0(input logic [7:0] d);
        step(1'b0, 2'b01, 2'b00, {8'h00, d}, 16'h00FF, 1'b0, 8'h00);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read data is sampled late in the access cycle, registered outputs just after the edge.
    initial begin
        logic [7:0] rd_s [N];
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < N; i++) rd_s[i] = rd_o[i];
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("d%0d rd_data", i), rd_s[i], e.rd[i]);
                    check($sformatf("d%0d field_value", i), fv_o[i], e.fv[i]);
                    check($sformatf("d%0d swmod_out", i), 8'(mod_o[i]), 8'(e.mod[i]));
                    check($sformatf("d%0d swacc_out", i), 8'(acc_o[i]), 8'(e.acc[i]));
                    check($sformatf("d%0d written_once", i), 8'(wo_o[i]), 8'(e.wo[i]));
                    check($sformatf("d%0d pulse_busy", i), 8'(busy_o[i]), 8'(e.busy[i]));
                    check($sformatf("d%0d parity_err", i), 8'(perr_o[i]), 8'h00);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] flipped;
        for (int i = 0; i < N; i++) begin
            mf[i] = C_RST[i]; mwo[i] = 1'b0; mdl[i] = -1;
        end

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        step(1'b1, 2'b11, 2'b11, 16'hFFFF, 16'hFFFF, 1'b1, 8'h66);
        settle();
        check("reset field d4", fv_o[4], 8'h80);
        check("reset field d2", fv_o[2], 8'h5A);
        check("reset swacc d0", 8'(acc_o[0]), 8'h00);

        // Lowest port wins over port 1.
        step(1'b0, 2'b11, 2'b00, 16'h3CA5, 16'hFFFF, 1'b0, 8'h00);
        settle();
        check("port select field", fv_o[0], 8'hA5);
        check("port select swmod", 8'(mod_o[0]), 8'h01);
        check("port select swacc", 8'(acc_o[0]), 8'h01);

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        step(1'b0, 2'b01, 2'b00, 16'h000F, 16'h003C, 1'b0, 8'h00);
        settle();
        check("woclr masked", fv_o[1], 8'hF3);

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        step(1'b0, 2'b00, 2'b01, 16'h0, 16'h0, 1'b0, 8'h0);
        #1;
        check("rclr read data", rd_o[2], 8'h5A);
        settle();
        check("rclr cleared", fv_o[2], 8'h00);
        step(1'b0, 2'b01, 2'b01, 16'h0011, 16'h00FF, 1'b0, 8'h00);
        settle();
        check("write beats rclr", fv_o[2], 8'h11);

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        wr0(8'h12);
        settle();
        check("rw1 first write", fv_o[3], 8'h12);
        check("rw1 lock set", 8'(wo_o[3]), 8'h01);
        wr0(8'h34);
        settle();
        check("rw1 locked value", fv_o[3], 8'h12);
        check("rw1 locked swmod", 8'(mod_o[3]), 8'h00);
        check("rw1 locked swacc", 8'(acc_o[3]), 8'h01);
        step(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 8'h77);
        settle();
        check("rw1 hw write", fv_o[3], 8'h77);

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) wr0(8'h01); else idle();
            settle();
            check($sformatf("pulse field t+%0d", k + 1), fv_o[5], (k == 3) ? 8'h00 : 8'h01);
            check($sformatf("pulse busy t+%0d", k + 1), 8'(busy_o[5]), (k == 3) ? 8'h00 : 8'h01);
        end
        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        for (int k = 0; k < 6; k++) begin
            if (k == 0 || k == 2) wr0(8'h01); else idle();
            settle();
            check($sformatf("repulse field t+%0d", k + 1), fv_o[5], (k == 5) ? 8'h00 : 8'h01);
        end

        step(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b0, 8'h0);
        wr0(8'h01);
        settle();
        check("mid-pulse lock", 8'(wo_o[4]), 8'h01);
        check("mid-pulse busy", 8'(busy_o[4]), 8'h01);
        step(1'b1, 2'b01, 2'b01, 16'h00FF, 16'h00FF, 1'b1, 8'h55);
        settle();
        check("reset abort field", fv_o[4], 8'h80);
        check("reset abort lock", 8'(wo_o[4]), 8'h00);
        check("reset abort busy", 8'(busy_o[4]), 8'h00);
        check("reset abort swacc", 8'(acc_o[4]), 8'h00);
        for (int k = 0; k < 4; k++) idle();
        settle();
        check("no residual clear", fv_o[4], 8'h80);

        for (int n = 0; n < 3000; n++) begin
            logic [1:0] w, rdv;
            logic [15:0] m;
            w   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            rdv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            m   = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            step($urandom_range(0, 63) == 0, w, rdv, 16'($urandom), m,
                 $urandom_range(0, 4) == 0, 8'($urandom));
        end
        idle();
        repeat (3) settle();
        check("scoreboard drained", 8'(exp_q.size()), 8'h00);

`ifdef SW_FIELD_CTRL_PARITY_EN
        @(negedge clk);
        flipped = fv_o[0] ^ 8'h01;
        force g_dut[0].u_dut.field_q = flipped;
        settle();
        release g_dut[0].u_dut.field_q;
        check("parity error flagged", 8'(perr_o[0]), 8'h01);
`else
        flipped = 8'h00;
        check("parity tied low", 8'(perr_o[0]) | flipped, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
